// File: rtl/pid_core.sv
// pid_core: multi-cycle discrete-time PID datapath.
// state | meaning
// IDLE  | waiting for a sample strobe with ena high
// ERR   | compute error from the captured setpoint/measurement
// PT    | proportional term
// IT    | integral update (with anti-windup and clamp) and integral term
// DT    | derivative term, remember error for next update
// OUT   | sum, shift, bias, saturate and publish the command
module pid_core #(
  parameter int GW       = 4,
  parameter int INT_LIM  = 1023,
  parameter int SHIFT    = 4,
  parameter int OUT_BIAS = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          sample,
  input  logic [7:0]    setpoint,
  input  logic [7:0]    measurement,
  input  logic [GW-1:0] kp,
  input  logic [GW-1:0] ki,
  input  logic [GW-1:0] kd,
  output logic [7:0]    out,
  output logic          out_valid,
  output logic          busy,
  output logic          overrun
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ERR  = 3'd1;
  localparam logic [2:0] S_PT   = 3'd2;
  localparam logic [2:0] S_IT   = 3'd3;
  localparam logic [2:0] S_DT   = 3'd4;
  localparam logic [2:0] S_OUT  = 3'd5;

  localparam logic signed [12:0] LIM  = 13'(INT_LIM);
  localparam logic signed [12:0] NLIM = -LIM;
  localparam logic signed [17:0] BIAS = 18'(OUT_BIAS);

  logic [2:0]          state;
  logic [7:0]          sp_q, meas_q;
  logic [GW-1:0]       kp_q, ki_q, kd_q;
  logic signed [8:0]   e_q, e_prev;
  logic signed [11:0]  integ;
  logic signed [17:0]  p_q, i_q, d_q;
  logic                sat_hi, sat_lo;

  logic signed [17:0]  kp_s, ki_s, kd_s, e_s, ep_s, integ_s;
  logic signed [12:0]  integ_sum;
  logic signed [11:0]  integ_next;
  logic signed [17:0]  sum_c, y_c;
  logic [7:0]          out_c;
  logic                hold;

  assign busy    = (state != S_IDLE);
  assign kp_s    = {{(18-GW){1'b0}}, kp_q};
  assign ki_s    = {{(18-GW){1'b0}}, ki_q};
  assign kd_s    = {{(18-GW){1'b0}}, kd_q};
  assign e_s     = {{9{e_q[8]}}, e_q};
  assign ep_s    = {{9{e_prev[8]}}, e_prev};
  assign integ_s = {{6{integ_next[11]}}, integ_next};

  // Integral candidate: frozen while the output is pinned in the error's direction.
  always_comb begin
    hold      = (sat_hi && !e_q[8] && (e_q != 9'sd0)) || (sat_lo && e_q[8]);
    integ_sum = {integ[11], integ} + {{4{e_q[8]}}, e_q};
    if (hold)                   integ_next = integ;
    else if (integ_sum > LIM)   integ_next = LIM[11:0];
    else if (integ_sum < NLIM)  integ_next = NLIM[11:0];
    else                        integ_next = integ_sum[11:0];
  end

  // Output stage: floor shift, bias, then saturate into 0..255.
  always_comb begin
    sum_c = p_q + i_q + d_q;
    y_c   = (sum_c >>> SHIFT) + BIAS;
    if (y_c > 18'sd255)     out_c = 8'hFF;
    else if (y_c < 18'sd0)  out_c = 8'h00;
    else                    out_c = y_c[7:0];
  end

  // Sequencer and datapath registers; ena low in any busy state abandons the update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sp_q      <= '0;
      meas_q    <= '0;
      kp_q      <= '0;
      ki_q      <= '0;
      kd_q      <= '0;
      e_q       <= '0;
      e_prev    <= '0;
      integ     <= '0;
      p_q       <= '0;
      i_q       <= '0;
      d_q       <= '0;
      sat_hi    <= 1'b0;
      sat_lo    <= 1'b0;
      out       <= 8'(OUT_BIAS);
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (sample && state != S_IDLE) overrun <= 1'b1;
      if (state == S_IDLE) begin
        if (ena && sample) begin
          sp_q   <= setpoint;
          meas_q <= measurement;
          kp_q   <= kp;
          ki_q   <= ki;
          kd_q   <= kd;
          state  <= S_ERR;
        end
      end else if (!ena) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_ERR: begin
            e_q   <= $signed({1'b0, sp_q}) - $signed({1'b0, meas_q});
            state <= S_PT;
          end
          S_PT: begin
            p_q   <= kp_s * e_s;
            state <= S_IT;
          end
          S_IT: begin
            integ <= integ_next;
            i_q   <= ki_s * integ_s;
            state <= S_DT;
          end
          S_DT: begin
            d_q    <= kd_s * (e_s - ep_s);
            e_prev <= e_q;
            state  <= S_OUT;
          end
          S_OUT: begin
            out       <= out_c;
            out_valid <= 1'b1;
            sat_hi    <= (y_c > 18'sd255);
            sat_lo    <= (y_c < 18'sd0);
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pid_core.sv
// Directed and randomized checks of pid_core against a plain-integer PID model.
module tb_pid_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       sample = 1'b0;
  logic [7:0] setpoint = '0;
  logic [7:0] measurement = '0;
  logic [3:0] kp = '0, ki = '0, kd = '0;
  logic [7:0] out;
  logic       out_valid, busy, overrun;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_integ, m_eprev, m_out;
  bit m_sathi, m_satlo, m_overrun;

  pid_core dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sample(sample),
    .setpoint(setpoint), .measurement(measurement),
    .kp(kp), .ki(ki), .kd(kd),
    .out(out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_integ = 0; m_eprev = 0; m_out = 128;
    m_sathi = 0; m_satlo = 0; m_overrun = 0;
  endtask

  // abrt: index of the busy cycle (0=ERR .. 4=OUT) in which ena is dropped, -1 for none
  task automatic model_update(int sp, int meas, int gp, int gi, int gd, int abrt);
    int e, p, it, d, sum, q, y, integ;
    e = sp - meas;
    p = gp * e;
    integ = m_integ;
    if (!((m_sathi && e > 0) || (m_satlo && e < 0))) begin
      integ = integ + e;
      if (integ > 1023)  integ = 1023;
      if (integ < -1023) integ = -1023;
    end
    it = gi * integ;
    d  = gd * (e - m_eprev);
    if (abrt < 0 || abrt >= 3) m_integ = integ;
    if (abrt < 0 || abrt >= 4) m_eprev = e;
    if (abrt < 0) begin
      sum = p + it + d;
      q = sum / 16;
      if (sum < 0 && (sum % 16) != 0) q = q - 1;
      y = q + 128;
      m_sathi = (y > 255);
      m_satlo = (y < 0);
      m_out = (y > 255) ? 255 : ((y < 0) ? 0 : y);
    end
  endtask

  // One update; extra: busy-cycle index at which a second sample is pulsed (-1 none)
  task automatic run(int sp, int meas, int gp, int gi, int gd, int abrt, int extra);
    int n;
    model_update(sp, meas, gp, gi, gd, abrt);
    if (extra >= 0 && extra <= 4) m_overrun = 1;
    @(negedge clk);
    setpoint = 8'(sp); measurement = 8'(meas);
    kp = 4'(gp); ki = 4'(gi); kd = 4'(gd);
    ena = 1'b1; sample = 1'b1;
    @(negedge clk);
    setpoint = 8'($urandom); measurement = 8'($urandom);
    kp = 4'($urandom); ki = 4'($urandom); kd = 4'($urandom);
    check("busy_after_start", busy, 1);
    for (int i = 0; i < 6; i++) begin
      sample = (i == extra);
      if (i == abrt) ena = 1'b0;
      else if (abrt >= 0 && i == abrt + 1) ena = 1'b1;
      @(negedge clk);
      n = i + 1;
      if (abrt >= 0) begin
        check("abort_busy", busy, (n <= abrt) ? 1 : 0);
        check("abort_no_valid", out_valid, 0);
      end else begin
        check("busy", busy, (n <= 4) ? 1 : 0);
        check("out_valid", out_valid, (n == 5) ? 1 : 0);
        if (n == 5) check("out", out, m_out);
      end
    end
    sample = 1'b0;
    ena = 1'b1;
    check("out_hold", out, m_out);
    check("overrun", overrun, m_overrun);
  endtask

  initial begin
    model_reset();
    #12 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out", out, 128);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);

    // proportional only: 133
    run(100, 80, 4, 0, 0, -1, -1);

    // integral: 135 then 138
    rst_n = 1'b0; model_reset(); #2 rst_n = 1'b1;
    run(100, 80, 4, 2, 0, -1, -1);
    run(100, 80, 4, 2, 0, -1, -1);

    // derivative: 131 then 128
    rst_n = 1'b0; model_reset(); #2 rst_n = 1'b1;
    run(100, 80, 0, 0, 3, -1, -1);
    run(100, 80, 0, 0, 3, -1, -1);

    // saturation high, held integral, then saturation low
    rst_n = 1'b0; model_reset(); #2 rst_n = 1'b1;
    run(255, 0, 15, 0, 0, -1, -1);
    run(255, 0, 15, 15, 0, -1, -1);
    run(100, 100, 0, 15, 0, -1, -1);
    run(0, 255, 15, 0, 0, -1, -1);

    // overrun and abort
    rst_n = 1'b0; model_reset(); #2 rst_n = 1'b1;
    run(100, 80, 4, 0, 0, -1, 1);
    run(100, 80, 4, 2, 0, 2, -1);
    run(100, 80, 4, 2, 0, -1, 4);

    // ena low in IDLE: sample ignored, no overrun
    @(negedge clk);
    ena = 1'b0; sample = 1'b1;
    @(negedge clk);
    sample = 1'b0; ena = 1'b1;
    check("idle_disabled_busy", busy, 0);
    @(negedge clk);
    check("idle_disabled_valid", out_valid, 0);

    // async reset in the middle of an update
    run(100, 80, 4, 2, 0, -1, 1);
    @(negedge clk);
    setpoint = 8'd100; measurement = 8'd80; kp = 4'd4; ki = 4'd2; kd = 4'd0;
    sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out", out, 128);
    check("midrst_busy", busy, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_valid", out_valid, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(100, 80, 4, 2, 0, -1, -1);

    // randomized updates, some aborted
    for (int k = 0; k < 40; k++) begin
      int a;
      a = ($urandom_range(3, 0) == 0) ? int'($urandom_range(4, 0)) : -1;
      run(int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
          int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
          int'($urandom_range(15, 0)), a, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
